// File: rtl/time_setter.sv
// Front-panel date/time setter: debounces five buttons, edits a shadow
// date/time with calendar-correct wrap, and commits it with a one-cycle load.
module time_setter #(
  parameter int DEB_CYCLES     = 20000,
  parameter int BLINK_CYCLES   = 5000000,
  parameter int TIMEOUT_CYCLES = 500000000,
  parameter int YEAR_MIN       = 2000,
  parameter int YEAR_MAX       = 2099
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        middle,
  input  logic [15:0] cur_year,
  input  logic [5:0]  cur_month,
  input  logic [10:0] cur_day,
  input  logic [10:0] cur_hour,
  input  logic [10:0] cur_minute,
  input  logic [10:0] cur_second,
  output logic [15:0] set_year,
  output logic [5:0]  set_month,
  output logic [10:0] set_day,
  output logic [10:0] set_hour,
  output logic [10:0] set_minute,
  output logic [10:0] set_second,
  output logic        load,
  output logic        editing,
  output logic [2:0]  field,
  output logic        blink
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;
  typedef enum logic [2:0] {EV_NONE, EV_UP, EV_DOWN, EV_LEFT, EV_RIGHT, EV_MID} event_t;

  // Button index: 0=up 1=down 2=left 3=right 4=middle
  logic [4:0]    raw, s1, s2, deb, deb_d, press;
  logic [DW-1:0] dcnt [5];

  assign raw = {middle, right, left, down, up};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int unsigned i = 0; i < 5; i++) dcnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;
      for (int unsigned i = 0; i < 5; i++) begin
        if (s2[i] != deb[i]) begin
          if (dcnt[i] == DW'(DEB_CYCLES - 1)) begin
            deb[i]  <= s2[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + 1'b1;
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  assign press = deb & ~deb_d;

  event_t ev;
  always_comb begin
    ev = EV_NONE;
    if      (press[4]) ev = EV_MID;
    else if (press[2]) ev = EV_LEFT;
    else if (press[3]) ev = EV_RIGHT;
    else if (press[0]) ev = EV_UP;
    else if (press[1]) ev = EV_DOWN;
  end

  function automatic logic [10:0] days_in(input logic [15:0] y, input logic [5:0] m);
    logic leap;
    leap = (y % 16'd4 == 16'd0) && ((y % 16'd100 != 16'd0) || (y % 16'd400 == 16'd0));
    case (m)
      6'd2:                     days_in = leap ? 11'd29 : 11'd28;
      6'd4, 6'd6, 6'd9, 6'd11:  days_in = 11'd30;
      default:                  days_in = 11'd31;
    endcase
  endfunction

  // Out-of-range values (e.g. captured unvalidated) snap to the minimum.
  function automatic logic [15:0] step(input logic [15:0] v, input logic [15:0] lo,
                                       input logic [15:0] hi, input logic dn);
    if (v < lo || v > hi)  step = lo;
    else if (dn)           step = (v == lo) ? hi : v - 16'd1;
    else                   step = (v == hi) ? lo : v + 16'd1;
  endfunction

  state_t        state, state_next;
  logic [15:0]   y_n;
  logic [5:0]    mo_n;
  logic [10:0]   d_n, h_n, mi_n, s_n, dim;
  logic [2:0]    f_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          blink_n, dn;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      set_year   <= '0;
      set_month  <= '0;
      set_day    <= '0;
      set_hour   <= '0;
      set_minute <= '0;
      set_second <= '0;
      field      <= '0;
      blink      <= 1'b0;
      bcnt       <= '0;
      tcnt       <= '0;
    end else begin
      state      <= state_next;
      set_year   <= y_n;
      set_month  <= mo_n;
      set_day    <= d_n;
      set_hour   <= h_n;
      set_minute <= mi_n;
      set_second <= s_n;
      field      <= f_n;
      blink      <= blink_n;
      bcnt       <= bcnt_n;
      tcnt       <= tcnt_n;
    end
  end

  always_comb begin
    state_next = state;
    y_n        = set_year;
    mo_n       = set_month;
    d_n        = set_day;
    h_n        = set_hour;
    mi_n       = set_minute;
    s_n        = set_second;
    f_n        = field;
    blink_n    = blink;
    bcnt_n     = bcnt;
    tcnt_n     = tcnt;
    dim        = '0;
    dn         = (ev == EV_DOWN);
    case (state)
      IDLE: begin
        if (ev == EV_MID) begin
          y_n        = cur_year;
          mo_n       = cur_month;
          d_n        = cur_day;
          h_n        = cur_hour;
          mi_n       = cur_minute;
          s_n        = cur_second;
          f_n        = '0;
          blink_n    = 1'b0;
          bcnt_n     = '0;
          tcnt_n     = '0;
          state_next = EDIT;
        end
      end
      EDIT: begin
        if (bcnt == BW'(BLINK_CYCLES - 1)) begin
          bcnt_n  = '0;
          blink_n = ~blink;
        end else begin
          bcnt_n = bcnt + 1'b1;
        end
        if (ev != EV_NONE)                          tcnt_n = '0;
        else if (tcnt == TW'(TIMEOUT_CYCLES - 1))   state_next = IDLE;
        else                                        tcnt_n = tcnt + 1'b1;
        case (ev)
          EV_MID:   state_next = COMMIT;
          EV_LEFT:  f_n = (field == 3'd0) ? 3'd5 : field - 3'd1;
          EV_RIGHT: f_n = (field >= 3'd5) ? 3'd0 : field + 3'd1;
          EV_UP, EV_DOWN: begin
            case (field)
              3'd0: begin
                y_n = step(set_year, 16'(YEAR_MIN), 16'(YEAR_MAX), dn);
                dim = days_in(y_n, set_month);
                if (set_day > dim) d_n = dim;
              end
              3'd1: begin
                mo_n = 6'(step(16'(set_month), 16'd1, 16'd12, dn));
                dim  = days_in(set_year, mo_n);
                if (set_day > dim) d_n = dim;
              end
              3'd2: begin
                dim = days_in(set_year, set_month);
                d_n = 11'(step(16'(set_day), 16'd1, 16'(dim), dn));
              end
              3'd3:    h_n  = 11'(step(16'(set_hour),   16'd0, 16'd23, dn));
              3'd4:    mi_n = 11'(step(16'(set_minute), 16'd0, 16'd59, dn));
              3'd5:    s_n  = 11'(step(16'(set_second), 16'd0, 16'd59, dn));
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state_next != EDIT) blink_n = 1'b0;
  end

  assign load    = (state == COMMIT);
  assign editing = (state == EDIT);

endmodule

// File: tb/tb_time_setter.sv
// Randomized and directed bench for time_setter, checked every cycle against
// a sample-history/arithmetic model of the button-to-date behaviour.
module tb_time_setter;
  localparam int DEB  = 4;
  localparam int BLK  = 8;
  localparam int TMO  = 50;
  localparam int YMIN = 2000;
  localparam int YMAX = 2100;

  localparam bit [4:0] B_UP = 5'd1, B_DN = 5'd2, B_LT = 5'd4, B_RT = 5'd8, B_MID = 5'd16;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, middle = 1'b0;
  logic [15:0] cur_year = '0;
  logic [5:0]  cur_month = '0;
  logic [10:0] cur_day = '0, cur_hour = '0, cur_minute = '0, cur_second = '0;
  logic [15:0] set_year;
  logic [5:0]  set_month;
  logic [10:0] set_day, set_hour, set_minute, set_second;
  logic        load, editing, blink;
  logic [2:0]  field;

  time_setter #(.DEB_CYCLES(DEB), .BLINK_CYCLES(BLK), .TIMEOUT_CYCLES(TMO),
                .YEAR_MIN(YMIN), .YEAR_MAX(YMAX)) dut (
    .clk(clk), .rst_n(rst_n), .up(up), .down(down), .left(left), .right(right),
    .middle(middle), .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
    .set_year(set_year), .set_month(set_month), .set_day(set_day), .set_hour(set_hour),
    .set_minute(set_minute), .set_second(set_second), .load(load), .editing(editing),
    .field(field), .blink(blink));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, load_seen = 0;
  bit started = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dim_of(input int y, input int m);
    bit leap;
    leap = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    if (m == 2) return leap ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic int wrap(input int v, input int lo, input int hi, input bit dn);
    if (v < lo || v > hi) return lo;
    if (dn) return (v == lo) ? hi : v - 1;
    return (v == hi) ? lo : v + 1;
  endfunction

  // Model: raw sample history per button (index 0 = previous cycle's raw level)
  bit hist [5][DEB+1];
  bit mdeb [5];
  bit mprev [5];
  bit mev [5];
  bit rawv [5];
  int m_y, m_mo, m_d, m_h, m_mi, m_s, m_f, k_entry, k_idle, pick;
  bit m_edit, m_commit, same;

  always @(posedge clk) begin
    rawv = '{up, down, left, right, middle};
    if (!rst_n) begin
      started = 1'b1;
      for (int b = 0; b < 5; b++) begin
        mdeb[b] = 0; mprev[b] = 0;
        for (int j = 0; j <= DEB; j++) hist[b][j] = 0;
      end
      m_y = 0; m_mo = 0; m_d = 0; m_h = 0; m_mi = 0; m_s = 0; m_f = 0;
      m_edit = 0; m_commit = 0; k_entry = 0; k_idle = 0;
    end else begin
      for (int b = 0; b < 5; b++) begin
        mev[b]   = mdeb[b] && !mprev[b];
        mprev[b] = mdeb[b];
        same = 1;
        for (int j = 2; j <= DEB; j++) if (hist[b][j] != hist[b][1]) same = 0;
        if (same && hist[b][1] != mdeb[b]) mdeb[b] = hist[b][1];
        for (int j = DEB; j > 0; j--) hist[b][j] = hist[b][j-1];
        hist[b][0] = rawv[b];
      end
      pick = -1;
      if      (mev[4]) pick = 4;
      else if (mev[2]) pick = 2;
      else if (mev[3]) pick = 3;
      else if (mev[0]) pick = 0;
      else if (mev[1]) pick = 1;
      if (m_commit) m_commit = 0;
      else if (!m_edit) begin
        if (pick == 4) begin
          m_y = int'(cur_year); m_mo = int'(cur_month); m_d = int'(cur_day);
          m_h = int'(cur_hour); m_mi = int'(cur_minute); m_s = int'(cur_second);
          m_f = 0; m_edit = 1; k_entry = 0; k_idle = 0;
        end
      end else begin
        k_entry++;
        if (pick < 0) begin
          k_idle++;
          if (k_idle == TMO) m_edit = 0;
        end else begin
          k_idle = 0;
          case (pick)
            4: begin m_edit = 0; m_commit = 1; end
            2: m_f = (m_f == 0) ? 5 : m_f - 1;
            3: m_f = (m_f >= 5) ? 0 : m_f + 1;
            default: begin
              case (m_f)
                0: begin m_y = wrap(m_y, YMIN, YMAX, pick == 1);
                         if (m_d > dim_of(m_y, m_mo)) m_d = dim_of(m_y, m_mo); end
                1: begin m_mo = wrap(m_mo, 1, 12, pick == 1);
                         if (m_d > dim_of(m_y, m_mo)) m_d = dim_of(m_y, m_mo); end
                2: m_d  = wrap(m_d, 1, dim_of(m_y, m_mo), pick == 1);
                3: m_h  = wrap(m_h, 0, 23, pick == 1);
                4: m_mi = wrap(m_mi, 0, 59, pick == 1);
                default: m_s = wrap(m_s, 0, 59, pick == 1);
              endcase
            end
          endcase
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (started) begin
      if (load) load_seen++;
      check("set_year",   int'(set_year),   m_y);
      check("set_month",  int'(set_month),  m_mo);
      check("set_day",    int'(set_day),    m_d);
      check("set_hour",   int'(set_hour),   m_h);
      check("set_minute", int'(set_minute), m_mi);
      check("set_second", int'(set_second), m_s);
      check("field",      int'(field),      m_f);
      check("editing",    int'(editing),    int'(m_edit));
      check("load",       int'(load),       int'(m_commit));
      check("blink",      int'(blink),      m_edit ? (k_entry / BLK) % 2 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit [4:0] m);
    {middle, right, left, down, up} = m;
  endtask

  task automatic press(input bit [4:0] m);
    @(negedge clk);
    drive(m);
    cyc(DEB + 4);
    drive(5'd0);
    cyc(DEB + 4);
  endtask

  task automatic set_cur(input int y, input int mo, input int d, input int h, input int mi, input int s);
    cur_year = 16'(y); cur_month = 6'(mo); cur_day = 11'(d);
    cur_hour = 11'(h); cur_minute = 11'(mi); cur_second = 11'(s);
  endtask

  task automatic feb_case(input int yr, input int expd);
    set_cur(yr, 1, 31, 12, 0, 0);
    press(B_MID);
    press(B_RT);
    press(B_UP);
    check("feb_month", int'(set_month), 2);
    check("feb_day",   int'(set_day),   expd);
    press(B_MID);
    check("feb_commit_editing", int'(editing), 0);
  endtask

  int ls, hold;
  bit [4:0] m;

  initial begin
    cyc(3);
    rst_n = 1'b1;
    check("reset_year", int'(set_year), 0);
    check("reset_field", int'(field), 0);
    // bounce shorter than the debounce window
    drive(B_UP); cyc(1); drive(5'd0); cyc(1); drive(B_UP); cyc(1); drive(5'd0); cyc(10);
    press(B_UP);
    check("idle_up_field", int'(field), 0);
    check("idle_up_editing", int'(editing), 0);

    feb_case(2024, 29);
    feb_case(2023, 28);
    feb_case(2100, 28);

    set_cur(2024, 3, 15, 0, 59, 30);
    press(B_MID);
    repeat (4) press(B_RT);
    check("field4", int'(field), 4);
    press(B_UP);
    check("minute_wrap_up", int'(set_minute), 0);
    press(B_DN);
    check("minute_wrap_dn", int'(set_minute), 59);
    press(B_LT);
    press(B_DN);
    check("hour_wrap_dn", int'(set_hour), 23);
    repeat (3) press(B_LT);
    check("field0", int'(field), 0);
    press(B_LT);
    check("field_wrap_left", int'(field), 5);
    press(B_MID);

    set_cur(2100, 6, 10, 8, 30, 0);
    press(B_MID);
    press(B_UP);
    check("year_wrap", int'(set_year), 2000);
    ls = load_seen;
    press(B_MID);
    check("load_once", load_seen - ls, 1);
    check("commit_year", int'(set_year), 2000);
    check("commit_editing", int'(editing), 0);

    set_cur(2050, 7, 4, 1, 2, 3);
    press(B_MID | B_UP);
    check("mid_up_editing", int'(editing), 1);
    check("mid_up_field", int'(field), 0);
    check("mid_up_year", int'(set_year), 2050);
    press(B_LT | B_RT);
    check("left_over_right", int'(field), 5);
    ls = load_seen;
    cyc(TMO + 10);
    check("timeout_editing", int'(editing), 0);
    check("timeout_no_load", load_seen - ls, 0);

    press(B_MID);
    check("pre_reset_editing", int'(editing), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_year", int'(set_year), 0);
    check("rst_day", int'(set_day), 0);
    check("rst_editing", int'(editing), 0);
    check("rst_field", int'(field), 0);
    check("rst_blink", int'(blink), 0);
    check("rst_load", int'(load), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 9) == 0)
          set_cur($urandom_range(1990, 2110), $urandom_range(0, 15), $urandom_range(0, 40),
                  $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
        else
          set_cur($urandom_range(YMIN, YMAX), $urandom_range(1, 12), $urandom_range(1, 31),
                  $urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      end
      if ($urandom_range(0, 7) == 0) m = 5'($urandom);
      else m = 5'(1 << $urandom_range(0, 4));
      hold = $urandom_range(1, 12);
      @(negedge clk);
      drive(m);
      cyc(hold);
      drive(5'd0);
      cyc($urandom_range(1, 12));
    end
    cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
